// File: rtl/ipm_xy_route_port.sv
// ipm_xy_route_port
// Router input-port stage. It takes two-phase bundled-data flits from a link
// and buffers them in a small FIFO. It computes an XY route on each head flit,
// claims the chosen output-port module with a PacketEnable level, and then
// streams the packet out on that port's two-phase channel. The claim is
// released through the Tailpassed return handshake.
//
// Flit layout:
//   [1:0]  type (01 head, 00 body, 10 tail, 11 single)
//   [4:2]  Loc  (head only, forwarded untouched)
//   [8:5]  Y    (head only)
//   [12:9] X    (head only)
// WORD_WIDTH must therefore be at least 13.
// FIFO_DEPTH must be a power of two and at least 2.

module ipm_xy_route_port #(
  parameter int WORD_WIDTH = 32,
  parameter int OUTPORTS   = 5,
  parameter int IN_PORT    = 0,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_up_i,
  input  logic [WORD_WIDTH-1:0] Data_up_i,
  output logic                  ack_up_o,
  output logic [OUTPORTS-1:0]   req_dw_o,
  output logic [WORD_WIDTH-1:0] Data_dw_o,
  input  logic [OUTPORTS-1:0]   ack_dw_i,
  output logic [OUTPORTS-1:0]   PacketEnable_dw_o,
  input  logic [OUTPORTS-1:0]   Tailpassed_up_i,
  output logic                  err_o
);

  localparam int SEL_W = (OUTPORTS > 1) ? $clog2(OUTPORTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [SEL_W-1:0] DIR_LOCAL = SEL_W'(0);
  localparam logic [SEL_W-1:0] DIR_NORTH = SEL_W'(1);
  localparam logic [SEL_W-1:0] DIR_EAST  = SEL_W'(2);
  localparam logic [SEL_W-1:0] DIR_SOUTH = SEL_W'(3);
  localparam logic [SEL_W-1:0] DIR_WEST  = SEL_W'(4);

  localparam logic [SEL_W-1:0] C_IN_PORT = SEL_W'(IN_PORT);
  localparam logic [3:0]       C_LOCAL_X = 4'(LOCAL_X);
  localparam logic [3:0]       C_LOCAL_Y = 4'(LOCAL_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROUTE,
    S_FWD,
    S_RELEASE,
    S_WAIT_LOW,
    S_DROP
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]        r_wrPtr;
  logic [PTR_W:0]        r_rdPtr;
  logic                  r_ackUp;
  logic [OUTPORTS-1:0]   r_reqDw;
  logic [OUTPORTS-1:0]   r_pe;
  logic [WORD_WIDTH-1:0] r_dataDw;
  logic                  r_err;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_lastSent;

  logic                  w_empty;
  logic                  w_full;
  logic [WORD_WIDTH-1:0] w_head;
  logic [1:0]            w_type;
  logic                  w_isHead;
  logic                  w_isLast;
  logic [3:0]            w_destX;
  logic [3:0]            w_destY;
  logic [SEL_W-1:0]      w_route;
  logic                  w_upPending;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_send;
  logic                  w_dwIdle;
  logic                  w_tpSel;
  logic [OUTPORTS-1:0]   w_selOneHot;

  // The extra pointer bit separates the full case from the empty case.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                   (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign w_head  = r_mem[r_rdPtr[PTR_W-1:0]];

  assign w_type   = w_head[1:0];
  assign w_isHead = (w_type == 2'b01) || (w_type == 2'b11);
  assign w_isLast = (w_type == 2'b10) || (w_type == 2'b11);
  assign w_destY  = w_head[8:5];
  assign w_destX  = w_head[12:9];

  // A pending flit is accepted when there is room. A read in the same cycle
  // also counts as room, so a full buffer keeps streaming.
  assign w_upPending = (req_up_i != r_ackUp);
  assign w_push      = w_upPending && (!w_full || w_pop);

  // The selected channel is idle when its two phases match.
  assign w_dwIdle = (r_reqDw[r_sel] == ack_dw_i[r_sel]);
  assign w_tpSel  = Tailpassed_up_i[r_sel];

  // XY routing: resolve X first, then Y; matching both means local delivery.
  always_comb begin
    w_route = DIR_LOCAL;
    if (w_destX > C_LOCAL_X) begin
      w_route = DIR_EAST;
    end else if (w_destX < C_LOCAL_X) begin
      w_route = DIR_WEST;
    end else if (w_destY > C_LOCAL_Y) begin
      w_route = DIR_NORTH;
    end else if (w_destY < C_LOCAL_Y) begin
      w_route = DIR_SOUTH;
    end
  end

  // Decode the latched direction into the enable pattern for the claim.
  always_comb begin
    w_selOneHot = '0;
    for (int i = 0; i < OUTPORTS; i++) begin
      w_selOneHot[i] = (r_sel == SEL_W'(i));
    end
  end

  // Decide when the FIFO head is consumed. Stray body/tail flits are dropped
  // in IDLE, a U-turn packet drains in DROP, and FWD consumes one flit per
  // completed downstream handshake until the last flit has gone out.
  always_comb begin
    w_pop  = 1'b0;
    w_send = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !w_isHead) begin
          w_pop = 1'b1;
        end
      end
      S_FWD: begin
        if (!r_lastSent && !w_empty && w_dwIdle) begin
          w_send = 1'b1;
          w_pop  = 1'b1;
        end
      end
      S_DROP: begin
        if (!w_empty) begin
          w_pop = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Buffer storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[PTR_W-1:0]] <= Data_up_i;
    end
  end

  // Maintain the FIFO pointers and acknowledge each accepted flit upstream on
  // the same edge it is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ackUp <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
        r_ackUp <= ~r_ackUp;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Packet control: route the head, claim the output, stream the flits,
  // then hand the claim back once the output reports the tail has passed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sel      <= DIR_LOCAL;
      r_reqDw    <= '0;
      r_dataDw   <= '0;
      r_pe       <= '0;
      r_err      <= 1'b0;
      r_lastSent <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_isHead) begin
              r_sel   <= w_route;
              r_state <= S_ROUTE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ROUTE: begin
          if (r_sel == C_IN_PORT) begin
            r_err   <= 1'b1;
            r_state <= S_DROP;
          end else if (!w_tpSel) begin
            r_pe       <= w_selOneHot;
            r_lastSent <= 1'b0;
            r_state    <= S_FWD;
          end
        end
        S_FWD: begin
          if (w_send) begin
            r_dataDw       <= w_head;
            r_reqDw[r_sel] <= ~r_reqDw[r_sel];
            r_lastSent     <= w_isLast;
          end else if (r_lastSent && w_dwIdle) begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_tpSel) begin
            r_pe    <= '0;
            r_state <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!w_tpSel) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!w_empty && w_isLast) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_up_o          = r_ackUp;
  assign req_dw_o          = r_reqDw;
  assign Data_dw_o         = r_dataDw;
  assign PacketEnable_dw_o = r_pe;
  assign err_o             = r_err;

  // The claim is never allowed to cover two outputs at once.
  assert property (@(posedge clk) disable iff (reset) $onehot0(r_pe));

endmodule

// File: tb/tb_ipm_xy_route_port.sv
// Testbench for ipm_xy_route_port.
// Two instances sit at router (1,1). Instance A faces Local (IN_PORT=0).
// Instance B faces East (IN_PORT=2), so East-bound packets are U-turns there.
// A background process plays the upstream link and the downstream OPMs.
// The main thread runs directed steps and checks them against constants.
`timescale 1ns/1ns

module tb_ipm_xy_route_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqUp  [2];
  logic [31:0] dataUp [2];
  logic        ackUp  [2];
  logic [4:0]  reqDw  [2];
  logic [31:0] dataDw [2];
  logic [4:0]  ackDw  [2];
  logic [4:0]  pe     [2];
  logic [4:0]  tp     [2];
  logic        err    [2];

  logic        sinkEn [2];
  int          ackCnt [2];
  logic        lastAck[2];
  logic [31:0] upQA[$];
  logic [31:0] upQB[$];
  logic [35:0] gotA[$];
  logic [35:0] gotB[$];

  int testsRun;
  int testsFailed;

  always #5 clk = ~clk;

  ipm_xy_route_port #(
    .WORD_WIDTH(32), .OUTPORTS(5), .IN_PORT(0),
    .LOCAL_X(1), .LOCAL_Y(1), .FIFO_DEPTH(4)
  ) dutA (
    .clk(clk), .reset(reset),
    .req_up_i(reqUp[0]), .Data_up_i(dataUp[0]), .ack_up_o(ackUp[0]),
    .req_dw_o(reqDw[0]), .Data_dw_o(dataDw[0]), .ack_dw_i(ackDw[0]),
    .PacketEnable_dw_o(pe[0]), .Tailpassed_up_i(tp[0]), .err_o(err[0])
  );

  ipm_xy_route_port #(
    .WORD_WIDTH(32), .OUTPORTS(5), .IN_PORT(2),
    .LOCAL_X(1), .LOCAL_Y(1), .FIFO_DEPTH(4)
  ) dutB (
    .clk(clk), .reset(reset),
    .req_up_i(reqUp[1]), .Data_up_i(dataUp[1]), .ack_up_o(ackUp[1]),
    .req_dw_o(reqDw[1]), .Data_dw_o(dataDw[1]), .ack_dw_i(ackDw[1]),
    .PacketEnable_dw_o(pe[1]), .Tailpassed_up_i(tp[1]), .err_o(err[1])
  );

  // Build a flit: tag in the top bits, then X, Y, Loc=101 and the type.
  function automatic logic [31:0] mkFlit(input logic [18:0] tag, input logic [3:0] x,
                                         input logic [3:0] y, input logic [1:0] typ);
    return {tag, x, y, 3'b101, typ};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [31:0] flit);
    if (inst == 0) upQA.push_back(flit);
    else           upQB.push_back(flit);
  endtask

  task automatic waitGot(input int inst, input int n, input string tag);
    int sz;
    for (int i = 0; i < 200; i++) begin
      sz = (inst == 0) ? gotA.size() : gotB.size();
      if (sz >= n) break;
      tick();
    end
    sz = (inst == 0) ? gotA.size() : gotB.size();
    checkOutput(tag, 64'(sz), 64'(n));
  endtask

  task automatic waitAck(input int inst, input int n, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (ackCnt[inst] >= n) break;
      tick();
    end
    checkOutput(tag, 64'(ackCnt[inst]), 64'(n));
  endtask

  task automatic checkGot(input int inst, input int idx, input logic [3:0] port,
                          input logic [31:0] data, input string tag);
    logic [35:0] obs;
    obs = '1;
    if (inst == 0) begin
      if (idx < gotA.size()) obs = gotA[idx];
    end else begin
      if (idx < gotB.size()) obs = gotB[idx];
    end
    checkOutput(tag, 64'(obs), 64'({port, data}));
  endtask

  task automatic pulseTailpassed(input int inst, input int port);
    tp[inst][port] = 1'b1;
    repeat (2) tick();
    tp[inst][port] = 1'b0;
    repeat (2) tick();
  endtask

  // Link models: count upstream acks, feed queued flits one per handshake,
  // and acknowledge every downstream request within a cycle while recording
  // which port it came from and the data it carried.
  initial begin
    for (int i = 0; i < 2; i++) begin
      reqUp[i] = 1'b0; dataUp[i] = '0; ackDw[i] = '0;
      ackCnt[i] = 0; lastAck[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (ackUp[i] !== lastAck[i]) begin
          ackCnt[i]++;
          lastAck[i] = ackUp[i];
        end
      end
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          reqUp[i] = 1'b0; ackDw[i] = '0;
        end
        upQA.delete();
        upQB.delete();
      end else begin
        if (reqUp[0] === ackUp[0] && upQA.size() > 0) begin
          dataUp[0] = upQA.pop_front();
          reqUp[0]  = ~reqUp[0];
        end
        if (reqUp[1] === ackUp[1] && upQB.size() > 0) begin
          dataUp[1] = upQB.pop_front();
          reqUp[1]  = ~reqUp[1];
        end
        for (int i = 0; i < 2; i++) begin
          if (sinkEn[i]) begin
            for (int p = 0; p < 5; p++) begin
              if (reqDw[i][p] !== ackDw[i][p]) begin
                if (i == 0) gotA.push_back({4'(p), dataDw[i]});
                else        gotB.push_back({4'(p), dataDw[i]});
                ackDw[i][p] = reqDw[i][p];
              end
            end
          end
        end
      end
    end
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int          base;
    int          ackBase;
    logic [31:0] h;
    logic [31:0] b1;
    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] pk [6];

    testsRun = 0; testsFailed = 0;
    tp[0] = '0; tp[1] = '0;
    sinkEn[0] = 1'b1; sinkEn[1] = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();

    // Reset state
    checkOutput("rstA_ackUp", 64'(ackUp[0]), 64'(0));
    checkOutput("rstA_reqDw", 64'(reqDw[0]), 64'(0));
    checkOutput("rstA_dataDw", 64'(dataDw[0]), 64'(0));
    checkOutput("rstA_pe", 64'(pe[0]), 64'(0));
    checkOutput("rstA_err", 64'(err[0]), 64'(0));
    checkOutput("rstB_all", 64'({ackUp[1], reqDw[1], pe[1], err[1], dataDw[1]}), 64'(0));
    reset = 1'b0;
    repeat (2) tick();

    // East-bound head/body/tail on A; checks latency and order
    h  = mkFlit(19'h00011, 4'd2, 4'd0, 2'b01);
    b1 = mkFlit(19'h00012, 4'd0, 4'd0, 2'b00);
    t  = mkFlit(19'h00013, 4'd0, 4'd0, 2'b10);
    base = gotA.size(); ackBase = ackCnt[0];
    applyStimulus(0, h); applyStimulus(0, b1); applyStimulus(0, t);
    for (int i = 0; i < 20 && ackUp[0] !== 1'b1; i++) tick();
    checkOutput("t1_headAcked", 64'(ackUp[0]), 64'(1));
    tick();
    checkOutput("t1_routeCyclePe", 64'(pe[0]), 64'(0));
    tick();
    checkOutput("t1_peEast", 64'(pe[0]), 64'(5'b00100));
    checkOutput("t1_noReqYet", 64'(reqDw[0]), 64'(0));
    tick();
    checkOutput("t1_reqToggle", 64'(reqDw[0]), 64'(5'b00100));
    checkOutput("t1_headData", 64'(dataDw[0]), 64'(h));
    waitGot(0, base + 3, "t1_flitCount");
    checkGot(0, base,     4'd2, h,  "t1_flit0");
    checkGot(0, base + 1, 4'd2, b1, "t1_flit1");
    checkGot(0, base + 2, 4'd2, t,  "t1_flit2");
    repeat (3) tick();
    checkOutput("t1_peHeld", 64'(pe[0]), 64'(5'b00100));
    tp[0][2] = 1'b1;
    tick();
    checkOutput("t1_peReleased", 64'(pe[0]), 64'(0));
    tp[0][2] = 1'b0;
    repeat (2) tick();
    checkOutput("t1_reqPhase", 64'(reqDw[0]), 64'(5'b00100));
    checkOutput("t1_upAcks", 64'(ackCnt[0] - ackBase), 64'(3));
    checkOutput("t1_noErr", 64'(err[0]), 64'(0));

    // Local single then West single on B
    s = mkFlit(19'h00021, 4'd1, 4'd1, 2'b11);
    base = gotB.size();
    applyStimulus(1, s);
    waitGot(1, base + 1, "t2_localCount");
    checkGot(1, base, 4'd0, s, "t2_localFlit");
    checkOutput("t2_peLocal", 64'(pe[1]), 64'(5'b00001));
    pulseTailpassed(1, 0);
    checkOutput("t2_peCleared", 64'(pe[1]), 64'(0));
    s = mkFlit(19'h00022, 4'd0, 4'd1, 2'b11);
    applyStimulus(1, s);
    waitGot(1, base + 2, "t2_westCount");
    checkGot(1, base + 1, 4'd4, s, "t2_westFlit");
    checkOutput("t2_reqPhase", 64'(reqDw[1]), 64'(5'b10001));
    pulseTailpassed(1, 4);

    // U-turn on B: dropped with error, then a legal North packet
    h  = mkFlit(19'h00041, 4'd2, 4'd1, 2'b01);
    b1 = mkFlit(19'h00042, 4'd0, 4'd0, 2'b00);
    t  = mkFlit(19'h00043, 4'd0, 4'd0, 2'b10);
    base = gotB.size(); ackBase = ackCnt[1];
    applyStimulus(1, h); applyStimulus(1, b1); applyStimulus(1, t);
    waitAck(1, ackBase + 3, "t4_allAcked");
    repeat (4) tick();
    checkOutput("t4_err", 64'(err[1]), 64'(1));
    checkOutput("t4_noForward", 64'(gotB.size()), 64'(base));
    checkOutput("t4_reqHeld", 64'(reqDw[1]), 64'(5'b10001));
    checkOutput("t4_noClaim", 64'(pe[1]), 64'(0));
    s = mkFlit(19'h00044, 4'd1, 4'd2, 2'b11);
    applyStimulus(1, s);
    waitGot(1, base + 1, "t4_northCount");
    checkGot(1, base, 4'd1, s, "t4_northFlit");
    pulseTailpassed(1, 1);
    checkOutput("t4_reqPhase", 64'(reqDw[1]), 64'(5'b10011));

    // Six-flit South packet on A with the downstream ack withheld
    pk[0] = mkFlit(19'h00031, 4'd1, 4'd0, 2'b01);
    for (int k = 1; k < 5; k++) pk[k] = mkFlit(19'h00031 + 19'(k), 4'd0, 4'd0, 2'b00);
    pk[5] = mkFlit(19'h00036, 4'd0, 4'd0, 2'b10);
    sinkEn[0] = 1'b0;
    base = gotA.size(); ackBase = ackCnt[0];
    for (int k = 0; k < 6; k++) applyStimulus(0, pk[k]);
    repeat (8) tick();
    checkOutput("t3_stallAcks", 64'(ackCnt[0] - ackBase), 64'(5));
    checkOutput("t3_dataHeld", 64'(dataDw[0]), 64'(pk[0]));
    checkOutput("t3_reqPending", 64'(reqDw[0]), 64'(5'b01100));
    repeat (12) tick();
    checkOutput("t3_stillStalled", 64'(ackCnt[0] - ackBase), 64'(5));
    checkOutput("t3_dataStable", 64'(dataDw[0]), 64'(pk[0]));
    sinkEn[0] = 1'b1;
    waitGot(0, base + 6, "t3_flitCount");
    for (int k = 0; k < 6; k++) checkGot(0, base + k, 4'd3, pk[k], "t3_flitOrder");
    checkOutput("t3_allAcked", 64'(ackCnt[0] - ackBase), 64'(6));
    pulseTailpassed(0, 3);

    // Tailpassed already high blocks the North claim; then a stray body flit
    tp[0][1] = 1'b1;
    s = mkFlit(19'h00051, 4'd1, 4'd2, 2'b11);
    base = gotA.size();
    applyStimulus(0, s);
    repeat (10) tick();
    checkOutput("t5_peBlocked", 64'(pe[0]), 64'(0));
    checkOutput("t5_noSendBlocked", 64'(gotA.size()), 64'(base));
    tp[0][1] = 1'b0;
    waitGot(0, base + 1, "t5_northCount");
    checkGot(0, base, 4'd1, s, "t5_northFlit");
    checkOutput("t5_peNorth", 64'(pe[0]), 64'(5'b00010));
    pulseTailpassed(0, 1);
    b1 = mkFlit(19'h00052, 4'd0, 4'd0, 2'b00);
    base = gotA.size(); ackBase = ackCnt[0];
    applyStimulus(0, b1);
    waitAck(0, ackBase + 1, "t5_bodyAcked");
    repeat (3) tick();
    checkOutput("t5_errBody", 64'(err[0]), 64'(1));
    checkOutput("t5_bodyDiscarded", 64'(gotA.size()), 64'(base));
    checkOutput("t5_noClaim", 64'(pe[0]), 64'(0));

    // Reset in the middle of an East packet on A
    h  = mkFlit(19'h00061, 4'd2, 4'd1, 2'b01);
    b1 = mkFlit(19'h00062, 4'd0, 4'd0, 2'b00);
    base = gotA.size();
    applyStimulus(0, h); applyStimulus(0, b1);
    waitGot(0, base + 2, "t6_twoSent");
    checkOutput("t6_peBefore", 64'(pe[0]), 64'(5'b00100));
    checkOutput("t6_reqBefore", 64'(reqDw[0]), 64'(5'b00110));
    @(posedge clk);
    #4 reset = 1'b1;
    #1;
    checkOutput("t6_rstAckUp", 64'(ackUp[0]), 64'(0));
    checkOutput("t6_rstReqDw", 64'(reqDw[0]), 64'(0));
    checkOutput("t6_rstDataDw", 64'(dataDw[0]), 64'(0));
    checkOutput("t6_rstPe", 64'(pe[0]), 64'(0));
    checkOutput("t6_rstErrA", 64'(err[0]), 64'(0));
    checkOutput("t6_rstErrB", 64'(err[1]), 64'(0));
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    s = mkFlit(19'h00071, 4'd0, 4'd0, 2'b11);
    base = gotA.size();
    applyStimulus(0, s);
    waitGot(0, base + 1, "t6_afterCount");
    checkGot(0, base, 4'd4, s, "t6_afterFlit");
    checkOutput("t6_afterReq", 64'(reqDw[0]), 64'(5'b10000));
    checkOutput("t6_afterErr", 64'(err[0]), 64'(0));
    pulseTailpassed(0, 4);
    checkOutput("t6_afterPe", 64'(pe[0]), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ipm_xy_route_port.md
Name: ipm_xy_route_port

Overview:
- Router input-port stage sitting directly upstream of the output-port switches (one OPM per direction).
- Accepts two-phase bundled-data flits from a link and buffers them in a small FIFO.
- Computes an XY route on each head flit, then claims the selected OPM with a PacketEnable level and forwards the whole packet on that port's two-phase channel.
- Releases the claim through the Tailpassed return handshake.

Parameters:
- WORD_WIDTH, 32, flit width; must be >= 13.
- OUTPORTS, 5, output directions: 0 Local, 1 North, 2 East, 3 South, 4 West.
- IN_PORT, 0, direction this input faces; a route equal to IN_PORT is illegal (U-turn).
- LOCAL_X, 0, router X coordinate (4 bit).
- LOCAL_Y, 0, router Y coordinate (4 bit).
- FIFO_DEPTH, 4, input buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock; all inputs sampled on rising edge; link signals are synchronous or pre-synchronised.
- reset  in  1  asynchronous, active-high.
- req_up_i  in  1  two-phase request from upstream link.
- Data_up_i  in  WORD_WIDTH  flit, valid while req_up_i != ack_up_o.
- ack_up_o  out  1  two-phase acknowledge to upstream.
- req_dw_o  out  OUTPORTS  per-OPM two-phase request.
- Data_dw_o  out  WORD_WIDTH  forwarded flit, shared by all OPMs.
- ack_dw_i  in  OUTPORTS  per-OPM two-phase acknowledge.
- PacketEnable_dw_o  out  OUTPORTS  one-hot claim of the selected OPM.
- Tailpassed_up_i  in  OUTPORTS  per-OPM tail-passed level.
- err_o  out  1  sticky protocol/route error.

Behaviour:
- Flit fields:
  - [1:0] type: 01 head, 00 body, 10 tail, 11 single-flit (head+tail).
  - Head flit: [4:2] Loc (forwarded untouched), [8:5] Y, [12:9] X.
- Reset: ack_up_o=0, req_dw_o=0, Data_dw_o=0, PacketEnable_dw_o=0, err_o=0, FIFO empty, FSM IDLE. Reset mid-packet drops everything immediately; the OPM sees its enable fall.
- Upstream intake:
  - If req_up_i != ack_up_o and FIFO not full: write Data_up_i and toggle ack_up_o on the same edge.
  - When full, ack is held; at most one flit per cycle.
  - A read and a write in the same cycle are both honoured while full.
- XY route, combinational on the FIFO head flit, registered in ROUTE:
  - X > LOCAL_X -> East; X < LOCAL_X -> West.
  - X equal: Y > LOCAL_Y -> North; Y < LOCAL_Y -> South; both equal -> Local.
- FSM states:
  - IDLE: if FIFO non-empty:
    - type head or single -> ROUTE.
    - type body or tail -> pop it, set err_o, stay in IDLE.
  - ROUTE (1 cycle): latch sel.
    - sel == IN_PORT -> DROP and set err_o.
    - Else wait until Tailpassed_up_i[sel]==0, then set PacketEnable_dw_o[sel]=1 -> FWD.
  - FWD:
    - When FIFO non-empty and req_dw_o[sel]==ack_dw_i[sel]: load Data_dw_o with the head entry, pop, toggle req_dw_o[sel] on the same edge.
    - Data_dw_o stays stable until the matching ack.
    - After the tail or single flit is sent and its ack is seen -> RELEASE.
  - RELEASE: wait Tailpassed_up_i[sel]==1, then clear PacketEnable_dw_o[sel] -> WAIT_LOW.
  - WAIT_LOW: wait Tailpassed_up_i[sel]==0 -> IDLE.
  - DROP: pop flits without forwarding until a tail or single is popped -> IDLE.
- Latency:
  - Head written at edge N -> ROUTE at N+1 -> PacketEnable high at N+2 (if Tailpassed is low) -> req_dw_o toggles at N+3.
  - Subsequent flits: one per downstream handshake; no bubble if the ack returns within one cycle.
- Outputs and invariants:
  - Only req_dw_o[sel] toggles during a packet; other bits hold their phase.
  - PacketEnable_dw_o is never multi-hot.
  - A head arriving while a packet is in FWD waits in the FIFO; the FIFO never reorders.
- err_o clears only on reset.

Test Plan:
- LOCAL_X=1, LOCAL_Y=1, IN_PORT=0; send head X=2,Y=0, body, tail -> PacketEnable_dw_o=5'b00100, req_dw_o[2] toggles 3 times with data in order; after Tailpassed_up_i[2] rises, enable returns to 0; ack_up_o toggles 3 times.
- Head X=1,Y=1 type 11 -> Local selected, single req_dw_o[0] toggle, release after Tailpassed_up_i[0] pulse; then head X=0,Y=1 -> West bit 4.
- Downstream ack withheld for 20 cycles with 6-flit packet, FIFO_DEPTH=4 -> ack_up_o stalls after 4 buffered (plus 1 in flight), Data_dw_o stable, no flit lost when ack resumes.
- IN_PORT=2, head routing East -> err_o=1, no req_dw_o toggle, all flits acked upstream; next legal packet forwarded normally.
- Tailpassed_up_i[1] held high before a North-bound head -> PacketEnable stays 0 until it falls; body flit as first flit -> err_o=1 and flit discarded.
- Assert reset mid-FWD after 2 flits -> all outputs 0 within the same cycle; the next packet after reset routes correctly.
